// File: rtl/hex_display_sched.sv
// hex_display_sched
//   Time-shares one external hex-to-seven-segment decoder across NDIG digits.
//   A packed hex value is captured through a valid/ready handshake, fed to the
//   decoder one nibble per clock, and the returned patterns are collected in a
//   stage register. All digits are then committed to seg_out in a single cycle,
//   so the display never shows a mix of old and new digits.
//
//   Optional feature (macro HEX_SCHED_LZ_BLANK_EN): leading-zero blanking at
//   commit; digit 0 is never blanked.
//
// Ports
//   clk         in   1        rising-edge clock
//   rst_n       in   1        asynchronous active-low reset
//   load_valid  in   1        source presents load_data
//   load_ready  out  1        combinational, high only in IDLE
//   load_data   in   4*NDIG   packed hex value, nibble i -> digit i
//   dec_nibble  out  4        nibble presented to the shared decoder (combinational)
//   dec_seg     in   7        decoder result for dec_nibble, active-low {g..a}
//   seg_out     out  7*NDIG   registered digit patterns, active-low
//   busy        out  1        high in SCAN or COMMIT (combinational)
//   done        out  1        registered one-cycle pulse with each seg_out update
module hex_display_sched #(
  parameter int unsigned NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [4*NDIG-1:0] load_data,
  output logic [3:0]        dec_nibble,
  input  logic [6:0]        dec_seg,
  output logic [7*NDIG-1:0] seg_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DW = 4 * NDIG;
  localparam int unsigned SW = 7 * NDIG;
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_idx_nxt;
  logic [DW-1:0]   r_shadow;
  logic [DW-1:0]   w_shadow_nxt;
  logic [SW-1:0]   r_stage;
  logic [SW-1:0]   w_stage_nxt;
  logic [SW-1:0]   r_seg_out;
  logic [SW-1:0]   w_seg_nxt;
  logic            r_done;
  logic            w_done_nxt;
  logic [3:0]      w_dec_nibble;
  logic [SW-1:0]   w_commit;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_shadow  <= '0;
      r_stage   <= '0;
      r_seg_out <= '1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_shadow  <= w_shadow_nxt;
      r_stage   <= w_stage_nxt;
      r_seg_out <= w_seg_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Pattern committed to seg_out, optionally with leading zeros blanked
  always_comb begin
    w_commit = r_stage;
`ifdef HEX_SCHED_LZ_BLANK_EN
    begin
      logic w_seen;
      w_seen = 1'b0;
      // Walk from the top digit down; blank until the first non-zero nibble
      for (int i = int'(NDIG) - 1; i > 0; i--) begin
        w_seen = w_seen | (r_shadow[4*i +: 4] != 4'h0);
        if (!w_seen) begin
          w_commit[7*i +: 7] = 7'h7F;
        end
      end
    end
`endif
  end

  // Next-state and datapath control
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_shadow_nxt = r_shadow;
    w_stage_nxt  = r_stage;
    w_seg_nxt    = r_seg_out;
    w_done_nxt   = 1'b0;
    w_dec_nibble = 4'h0;

    case (r_state)
      S_IDLE: begin
        if (load_valid) begin
          w_shadow_nxt = load_data;
          w_idx_nxt    = '0;
          w_state_nxt  = S_SCAN;
        end
      end

      S_SCAN: begin
        // Select the current nibble and capture its decoded pattern
        for (int i = 0; i < int'(NDIG); i++) begin
          if (r_idx == IW'(i)) begin
            w_dec_nibble           = r_shadow[4*i +: 4];
            w_stage_nxt[7*i +: 7]  = dec_seg;
          end
        end
        if (r_idx == IW'(NDIG - 1)) begin
          w_state_nxt = S_COMMIT;
        end else begin
          w_idx_nxt = r_idx + IW'(1);
        end
      end

      S_COMMIT: begin
        w_seg_nxt   = w_commit;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign load_ready = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign dec_nibble = w_dec_nibble;
  assign seg_out    = r_seg_out;
  assign done       = r_done;

endmodule
